// File: rtl/dcom_uart_pkg.sv
// Shared constants and state encoding for the UART com-port scheduler.
// Imported by the interface, the round-robin picker's users and the scheduler top.
package dcom_uart_pkg;

  localparam int          BYTE_W      = 8;
  localparam logic [15:0] TIMEOUT_DEF = 16'd1000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    GUARD     = 2'd2,
    GUARD_REL = 2'd3
  } state_t;

endpackage

// File: rtl/dcom_uart_sched_if.sv
// Requester, UART and receive-drain signals of the scheduler.
// master is the scheduler side, slave is the environment (requesters, UART core, consumer).
interface dcom_uart_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  import dcom_uart_pkg::*;

  logic [NREQ-1:0]        TxReq;
  logic [NREQ-1:0]        TxLast;
  logic [BYTE_W*NREQ-1:0] TxData;
  logic [NREQ-1:0]        TxAck;
  logic [IDW-1:0]         Owner;
  logic                   Busy;
  logic                   Abort;
  logic                   UartWrite;
  logic [BYTE_W-1:0]      UartDataIn;
  logic                   UartTHEmpty;
  logic                   UartRead;
  logic                   UartDataReady;
  logic [BYTE_W-1:0]      UartDataOut;
  logic                   RxValid;
  logic [BYTE_W-1:0]      RxData;
  logic                   RxReady;

  modport master (
    input  TxReq, TxLast, TxData, UartTHEmpty, UartDataReady, UartDataOut, RxReady,
    output TxAck, Owner, Busy, Abort, UartWrite, UartDataIn, UartRead, RxValid, RxData
  );

  modport slave (
    output TxReq, TxLast, TxData, UartTHEmpty, UartDataReady, UartDataOut, RxReady,
    input  TxAck, Owner, Busy, Abort, UartWrite, UartDataIn, UartRead, RxValid, RxData
  );

endinterface

// File: rtl/dcom_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from ptr with wrap.
// found is low when req is all zeros; idx is then 0.
module dcom_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] cand;

  // NOTE: every variable written here gets a default first, otherwise a path
  // that skips the assignment infers a latch.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
    for (int i = N - 1; i >= 0; i--) begin
      cand = W'((int'(ptr) + i) % N);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcom_uart_sched.sv
// Packet-granular round-robin sharing of one UART transmit port between NREQ requesters,
// with owner-stall timeout, plus a guarded valid/ready drain of the UART receive side.
module dcom_uart_sched
  import dcom_uart_pkg::*;
#(
  parameter int             NREQ    = 4,
  parameter int             IDW     = 2,
  parameter int             TOW     = 16,
  parameter logic [TOW-1:0] TIMEOUT = TOW'(TIMEOUT_DEF)
) (
  input logic               PCLK,
  input logic               PRST,
  dcom_uart_sched_if.master bus
);

  state_t              state;
  logic [IDW-1:0]      ptr;
  logic [IDW-1:0]      owner;
  logic [TOW-1:0]      cnt;
  logic                busy;
  logic [BYTE_W-1:0]   data_q;
  logic                rx_guard;

  logic                own_req;
  logic                own_last;
  logic [BYTE_W-1:0]   own_data;
  logic                fire;
  logic                expire;
  logic                rx_valid;
  logic                rd;
  logic [IDW-1:0]      win;
  logic                found;
  logic [IDW-1:0]      nxt;

  dcom_rr_pick #(.N(NREQ), .W(IDW)) u_pick (
    .req   (bus.TxReq),
    .ptr   (ptr),
    .idx   (win),
    .found (found)
  );

  assign own_req  = bus.TxReq[owner];
  assign own_last = bus.TxLast[owner];
  assign own_data = bus.TxData[{owner, 3'b000} +: BYTE_W];

  // A rising owner request on the expiry cycle wins over the abort.
  assign fire   = (state == SEND) && own_req && bus.UartTHEmpty;
  assign expire = (state == SEND) && !own_req && (cnt == TIMEOUT - 1'b1);
  assign nxt    = (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;

  assign bus.UartWrite  = fire;
  assign bus.UartDataIn = fire ? own_data : data_q;
  assign bus.TxAck      = fire ? (NREQ'(1) << owner) : '0;
  assign bus.Abort      = expire;
  assign bus.Busy       = busy;
  assign bus.Owner      = owner;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge PCLK) begin
    if (PRST) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner <= win;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SEND;
          end
        end
        SEND: begin
          if (fire) begin
            data_q <= own_data;
            cnt    <= '0;
            state  <= own_last ? GUARD_REL : GUARD;
          end else if (expire) begin
            ptr   <= nxt;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else if (!own_req) begin
            // Waiting only on THEmpty is not an owner stall.
            cnt <= cnt + 1'b1;
          end
        end
        // THEmpty is stale for one cycle after a write.
        GUARD: state <= SEND;
        GUARD_REL: begin
          ptr   <= nxt;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // DataReady clears one cycle after Read; masking that cycle prevents a double read.
  assign rx_valid    = bus.UartDataReady && !rx_guard;
  assign rd          = rx_valid && bus.RxReady;
  assign bus.RxValid = rx_valid;
  assign bus.RxData  = bus.UartDataOut;
  assign bus.UartRead = rd;

  always_ff @(posedge PCLK) begin
    if (PRST) rx_guard <= 1'b0;
    else      rx_guard <= rd;
  end

endmodule

// File: tb/tb_dcom_uart_sched.sv
// Directed bench for dcom_uart_sched: a queue-driven requester model feeds bytes,
// expected writes/reads/aborts go to scoreboards popped by negedge monitors.
module tb_dcom_uart_sched;

  localparam int NREQ = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } tx_item_t;

  typedef struct packed {
    logic [1:0] owner;
    logic [7:0] data;
  } wr_t;

  logic PCLK;
  logic PRST;

  dcom_uart_sched_if #(.NREQ(NREQ), .IDW(2)) bus ();

  dcom_uart_sched #(.NREQ(NREQ), .IDW(2), .TOW(16), .TIMEOUT(16'd16)) dut (
    .PCLK (PCLK),
    .PRST (PRST),
    .bus  (bus)
  );

  int n_cmp   = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_wr = -1;

  tx_item_t   txq [NREQ][$];
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  int         exp_ab[$];

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm, input logic [31:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: actual %0h required no event (t=%0t)", nm, act, $time);
  endtask

  task automatic push_tx(input int r, input logic [7:0] d, input logic l);
    tx_item_t it;
    it.data = d;
    it.last = l;
    txq[r].push_back(it);
  endtask

  task automatic expect_wr(input int o, input logic [7:0] d);
    wr_t w;
    w.owner = 2'(o);
    w.data  = d;
    exp_wr.push_back(w);
  endtask

  task automatic wait_busy(input logic v, input string nm);
    int n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (bus.Busy !== v && n < 200);
    check(nm, bus.Busy, v);
  endtask

  task automatic wait_ack(input int r, input string nm);
    int n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (bus.TxAck[r] !== 1'b1 && n < 200);
    check(nm, bus.TxAck[r], 1);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while ((exp_wr.size() != 0 || bus.Busy !== 1'b0) && n < 400);
    check(nm, exp_wr.size(), 0);
  endtask

  // Requester model: present the head of each queue, pop it once acknowledged.
  initial begin
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   lst;
    logic [8*NREQ-1:0] dat;
    req = '0;
    lst = '0;
    dat = '0;
    bus.TxReq  = '0;
    bus.TxLast = '0;
    bus.TxData = '0;
    forever begin
      @(negedge PCLK);
      ack = bus.TxAck;
      @(posedge PCLK);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i] && txq[i].size() > 0) void'(txq[i].pop_front());
        if (txq[i].size() > 0) begin
          req[i]         = 1'b1;
          lst[i]         = txq[i][0].last;
          dat[8*i +: 8]  = txq[i][0].data;
        end else begin
          req[i] = 1'b0;
        end
      end
      bus.TxReq  = req;
      bus.TxLast = lst;
      bus.TxData = dat;
    end
  end

  // Monitors: each presented write/read/abort pops its scoreboard.
  always @(negedge PCLK) begin
    wr_t e;
    if (bus.UartWrite === 1'b1) begin
      if (exp_wr.size() == 0) begin
        flag("wr_unexpected", {22'b0, bus.Owner, bus.UartDataIn});
      end else begin
        e = exp_wr.pop_front();
        check("wr_data", bus.UartDataIn, e.data);
        check("wr_owner", bus.Owner, e.owner);
        check("wr_ack", bus.TxAck, 32'(1) << e.owner);
      end
      if (last_wr >= 0) check("wr_gap_ge2", (cyc - last_wr) >= 2, 1);
      last_wr = cyc;
    end
    if (bus.UartRead === 1'b1) begin
      if (exp_rd.size() == 0) flag("rd_unexpected", bus.RxData);
      else                    check("rd_data", bus.RxData, exp_rd.pop_front());
    end
    if (bus.Abort === 1'b1) begin
      if (exp_ab.size() == 0) flag("abort_unexpected", bus.Owner);
      else                    check("abort_owner", bus.Owner, exp_ab.pop_front());
    end
  end

  initial begin
    int n;
    PRST              = 1'b1;
    bus.UartTHEmpty   = 1'b1;
    bus.UartDataReady = 1'b0;
    bus.UartDataOut   = '0;
    bus.RxReady       = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_busy", bus.Busy, 0);
    check("rst_abort", bus.Abort, 0);
    check("rst_txack", bus.TxAck, 0);
    check("rst_write", bus.UartWrite, 0);
    check("rst_read", bus.UartRead, 0);
    check("rst_rxvalid", bus.RxValid, 0);
    check("rst_datain", bus.UartDataIn, 0);
    check("rst_owner", bus.Owner, 0);
    @(posedge PCLK);
    #1;
    PRST = 1'b0;

    // Single byte: write in the first busy cycle, grant dropped two cycles later.
    push_tx(2, 8'hA5, 1'b1);
    expect_wr(2, 8'hA5);
    wait_busy(1'b1, "t1_grant");
    check("t1_write_c1", bus.UartWrite, 1);
    check("t1_ack_c1", bus.TxAck, 4'b0100);
    @(negedge PCLK);
    check("t1_busy_c2", bus.Busy, 1);
    check("t1_nowrite_c2", bus.UartWrite, 0);
    check("t1_hold_data", bus.UartDataIn, 8'hA5);
    @(negedge PCLK);
    check("t1_busy_c3", bus.Busy, 0);
    // Pointer is now 3: requester 3 beats requester 0.
    push_tx(0, 8'h10, 1'b1);
    push_tx(3, 8'h13, 1'b1);
    expect_wr(3, 8'h13);
    expect_wr(0, 8'h10);
    drain("t1_rr_drain");

    // Packet hold: requester 1 waits until requester 0's last byte.
    push_tx(0, 8'h11, 1'b0);
    push_tx(0, 8'h22, 1'b0);
    push_tx(0, 8'h33, 1'b1);
    expect_wr(0, 8'h11);
    expect_wr(0, 8'h22);
    expect_wr(0, 8'h33);
    wait_busy(1'b1, "t2_grant");
    check("t2_owner0", bus.Owner, 0);
    push_tx(1, 8'h44, 1'b1);
    expect_wr(1, 8'h44);
    drain("t2_drain");

    // THEmpty backpressure longer than the timeout: no write, no abort.
    @(posedge PCLK);
    #1;
    bus.UartTHEmpty = 1'b0;
    push_tx(2, 8'h55, 1'b1);
    expect_wr(2, 8'h55);
    wait_busy(1'b1, "t3_grant");
    n = 0;
    repeat (50) begin
      @(negedge PCLK);
      if (bus.UartWrite === 1'b1) n++;
    end
    check("t3_no_write", n, 0);
    @(posedge PCLK);
    #1;
    bus.UartTHEmpty = 1'b1;
    @(negedge PCLK);
    check("t3_fire_first", bus.UartWrite, 1);
    drain("t3_drain");

    // Timeout: owner 3 stalls after a non-last byte, requester 0 takes over.
    push_tx(3, 8'h66, 1'b0);
    push_tx(0, 8'h77, 1'b1);
    expect_wr(3, 8'h66);
    expect_wr(0, 8'h77);
    exp_ab.push_back(3);
    wait_ack(3, "t4_ack");
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (bus.Abort !== 1'b1 && n < 40);
    check("t4_abort_lat", n, 17);
    @(negedge PCLK);
    check("t4_busy_after", bus.Busy, 0);
    wait_busy(1'b1, "t4_regrant");
    check("t4_owner_next", bus.Owner, 0);
    drain("t4_drain");

    // Receive drain: one read, guard cycle masks the stale DataReady.
    @(posedge PCLK);
    #1;
    bus.UartDataOut   = 8'h3C;
    bus.UartDataReady = 1'b1;
    bus.RxReady       = 1'b1;
    exp_rd.push_back(8'h3C);
    @(negedge PCLK);
    check("t5_read", bus.UartRead, 1);
    @(negedge PCLK);
    check("t5_guard_valid", bus.RxValid, 0);
    check("t5_guard_read", bus.UartRead, 0);
    @(posedge PCLK);
    #1;
    bus.UartDataReady = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge PCLK);
      if (bus.UartRead === 1'b1) n++;
    end
    check("t5_single_read", n, 0);
    @(posedge PCLK);
    #1;
    bus.UartDataOut   = 8'h5A;
    bus.UartDataReady = 1'b1;
    bus.RxReady       = 1'b0;
    @(negedge PCLK);
    check("t5_valid_wait", bus.RxValid, 1);
    check("t5_noread_wait", bus.UartRead, 0);
    check("t5_rxdata", bus.RxData, 8'h5A);
    @(posedge PCLK);
    #1;
    bus.RxReady = 1'b1;
    exp_rd.push_back(8'h5A);
    @(negedge PCLK);
    check("t5_read2", bus.UartRead, 1);
    @(posedge PCLK);
    #1;
    @(posedge PCLK);
    #1;
    bus.UartDataReady = 1'b0;
    bus.RxReady       = 1'b0;

    // Move the pointer to 2 so a stale pointer after reset would pick requester 3.
    push_tx(1, 8'h99, 1'b1);
    expect_wr(1, 8'h99);
    drain("t6_pre_drain");

    // Reset while in GUARD: grant dropped silently, pointer back to 0.
    push_tx(3, 8'h81, 1'b0);
    push_tx(3, 8'h82, 1'b1);
    expect_wr(3, 8'h81);
    wait_ack(3, "t6_ack");
    @(posedge PCLK);
    #1;
    PRST = 1'b1;
    push_tx(1, 8'h91, 1'b1);
    expect_wr(1, 8'h91);
    expect_wr(3, 8'h82);
    @(negedge PCLK);
    check("t6_guard_abort", bus.Abort, 0);
    @(posedge PCLK);
    #1;
    PRST = 1'b0;
    @(negedge PCLK);
    check("t6_busy", bus.Busy, 0);
    check("t6_abort", bus.Abort, 0);
    check("t6_datain", bus.UartDataIn, 0);
    wait_busy(1'b1, "t6_regrant");
    check("t6_owner_low", bus.Owner, 1);
    drain("t6_drain");

    repeat (4) @(negedge PCLK);
    check("left_wr", exp_wr.size(), 0);
    check("left_rd", exp_rd.size(), 0);
    check("left_abort", exp_ab.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
